// File: rtl/regfile_tagged_mp.sv
// Rename-aware register file: per-entry data/valid/producer-tag, multi-lane decode claims,
// multi-port tagged writeback and a registered read stage. Optional REGFILE_ZERO_REG_EN hardwires entry 0.
module regfile_tagged_mp #(
  parameter int OPRAND_WIDTH  = 16,
  parameter int ARRAY_ENTRY   = 32,
  parameter int REGNAME_WIDTH = 5,
  parameter int ROB_TAG_WIDTH = 4,
  parameter int DEC_LANES     = 2,
  parameter int WB_PORTS      = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic [DEC_LANES*2*REGNAME_WIDTH-1:0]      dec_read_addr,
  input  logic [DEC_LANES*2-1:0]                    dec_read_en,
  input  logic [DEC_LANES*REGNAME_WIDTH-1:0]        dec_write_addr,
  input  logic [DEC_LANES-1:0]                      dec_write_en,
  input  logic [DEC_LANES*ROB_TAG_WIDTH-1:0]        dec_write_tag,
  input  logic [WB_PORTS*REGNAME_WIDTH-1:0]         rob_WB_target,
  input  logic [WB_PORTS*OPRAND_WIDTH-1:0]          rob_WB_data,
  input  logic [WB_PORTS*ROB_TAG_WIDTH-1:0]         rob_WB_tag,
  input  logic [WB_PORTS-1:0]                       rob_WB_en,
  output logic [DEC_LANES*2*OPRAND_WIDTH-1:0]       rob_read_data,
  output logic [DEC_LANES*2-1:0]                    rob_read_valid_bit,
  output logic [DEC_LANES*2*ROB_TAG_WIDTH-1:0]      rob_read_tag,
  output logic [DEC_LANES*2-1:0]                    rob_read_ready
);

  localparam int SLOTS = DEC_LANES * 2;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic        [OPRAND_WIDTH-1:0]  data_q  [ARRAY_ENTRY];
  logic        [ARRAY_ENTRY-1:0]   valid_q;
  logic        [ROB_TAG_WIDTH-1:0] tag_q   [ARRAY_ENTRY];
  logic        [OPRAND_WIDTH-1:0]  data_d  [ARRAY_ENTRY];
  logic        [ARRAY_ENTRY-1:0]   valid_d;
  logic        [ROB_TAG_WIDTH-1:0] tag_d   [ARRAY_ENTRY];

  logic [REGNAME_WIDTH-1:0] rd_addr  [SLOTS];
  logic [REGNAME_WIDTH-1:0] cl_addr  [DEC_LANES];
  logic [ROB_TAG_WIDTH-1:0] cl_tag   [DEC_LANES];
  logic [REGNAME_WIDTH-1:0] wb_tgt   [WB_PORTS];
  logic [OPRAND_WIDTH-1:0]  wb_data  [WB_PORTS];
  logic [ROB_TAG_WIDTH-1:0] wb_tag   [WB_PORTS];

  logic [OPRAND_WIDTH-1:0]  view_data_p0  [SLOTS];
  logic [SLOTS-1:0]         view_valid_p0;
  logic [ROB_TAG_WIDTH-1:0] view_tag_p0   [SLOTS];

  logic [SLOTS*OPRAND_WIDTH-1:0]  rd_data_p1;
  logic [SLOTS-1:0]               rd_valid_p1;
  logic [SLOTS*ROB_TAG_WIDTH-1:0] rd_tag_p1;
  logic [SLOTS-1:0]               vld_p1;

  function automatic logic in_range(input logic [REGNAME_WIDTH-1:0] a);
    return 32'(a) < 32'(ARRAY_ENTRY);
  endfunction

  // Entry 0 is never written when hardwired; out-of-range names are never written.
  function automatic logic writable(input logic [REGNAME_WIDTH-1:0] a);
    return in_range(a) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    for (int k = 0; k < SLOTS; k++)
      rd_addr[k] = dec_read_addr[k*REGNAME_WIDTH +: REGNAME_WIDTH];
    for (int i = 0; i < DEC_LANES; i++) begin
      cl_addr[i] = dec_write_addr[i*REGNAME_WIDTH +: REGNAME_WIDTH];
      cl_tag[i]  = dec_write_tag[i*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_tgt[p]  = rob_WB_target[p*REGNAME_WIDTH +: REGNAME_WIDTH];
      wb_data[p] = rob_WB_data[p*OPRAND_WIDTH +: OPRAND_WIDTH];
      wb_tag[p]  = rob_WB_tag[p*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
    end
  end

  // Next array state: writebacks first, then claims (which win on valid/tag), then flush.
  always_comb begin
    for (int e = 0; e < ARRAY_ENTRY; e++) begin
      data_d[e]  = data_q[e];
      valid_d[e] = valid_q[e];
      tag_d[e]   = tag_q[e];
      for (int p = 0; p < WB_PORTS; p++) begin
        if (rob_WB_en[p] && (wb_tgt[p] == REGNAME_WIDTH'(e))) begin
          data_d[e]  = wb_data[p];
          valid_d[e] = valid_q[e] | (tag_q[e] == wb_tag[p]);
        end
      end
      for (int i = 0; i < DEC_LANES; i++) begin
        if (!flush && dec_write_en[i] && (cl_addr[i] == REGNAME_WIDTH'(e))) begin
          valid_d[e] = 1'b0;
          tag_d[e]   = cl_tag[i];
        end
      end
      if (flush)
        valid_d[e] = 1'b1;
      if (ZERO_REG && (e == 0)) begin
        data_d[e]  = '0;
        valid_d[e] = 1'b1;
        tag_d[e]   = '0;
      end
    end
  end

  // Read view: array after this cycle's writebacks, overlaid with claims from older lanes.
  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      view_data_p0[k]  = '0;
      view_valid_p0[k] = 1'b1;
      view_tag_p0[k]   = '0;
      if (in_range(rd_addr[k])) begin
        view_data_p0[k]  = data_q[rd_addr[k]];
        view_valid_p0[k] = valid_q[rd_addr[k]];
        view_tag_p0[k]   = tag_q[rd_addr[k]];
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (rob_WB_en[p] && writable(rd_addr[k]) && (wb_tgt[p] == rd_addr[k])) begin
          view_data_p0[k]  = wb_data[p];
          view_valid_p0[k] = valid_q[rd_addr[k]] | (tag_q[rd_addr[k]] == wb_tag[p]);
        end
      end
      for (int m = 0; m < DEC_LANES; m++) begin
        if ((m < k / 2) && dec_write_en[m] && writable(rd_addr[k]) && (cl_addr[m] == rd_addr[k])) begin
          view_valid_p0[k] = 1'b0;
          view_tag_p0[k]   = cl_tag[m];
        end
      end
    end
  end

  // p0 -> p1: array update and registered read stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ARRAY_ENTRY; e++) begin
        data_q[e] <= '0;
        tag_q[e]  <= '0;
      end
      valid_q     <= '1;
      rd_data_p1  <= '0;
      rd_valid_p1 <= '1;
      rd_tag_p1   <= '0;
      vld_p1      <= '0;
    end else begin
      for (int e = 0; e < ARRAY_ENTRY; e++) begin
        data_q[e] <= data_d[e];
        tag_q[e]  <= tag_d[e];
      end
      valid_q <= valid_d;
      for (int k = 0; k < SLOTS; k++) begin
        vld_p1[k] <= dec_read_en[k] && !flush;
        if (dec_read_en[k] && !flush) begin
          rd_data_p1[k*OPRAND_WIDTH +: OPRAND_WIDTH]   <= view_data_p0[k];
          rd_valid_p1[k]                               <= view_valid_p0[k];
          rd_tag_p1[k*ROB_TAG_WIDTH +: ROB_TAG_WIDTH]  <= view_tag_p0[k];
        end
      end
    end
  end

  assign rob_read_data      = rd_data_p1;
  assign rob_read_valid_bit = rd_valid_p1;
  assign rob_read_tag       = rd_tag_p1;
  assign rob_read_ready     = vld_p1;

endmodule

// File: tb/tb_regfile_tagged_mp.sv
// Scoreboard bench for regfile_tagged_mp: stimulus pushes per-slot expectations, a negedge monitor pops and compares.
module tb_regfile_tagged_mp;

  localparam int OW = 16, AE = 32, RW = 5, TW = 4, DL = 2, WP = 2, SL = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [SL*RW-1:0]  dec_read_addr;
  logic [SL-1:0]     dec_read_en;
  logic [DL*RW-1:0]  dec_write_addr;
  logic [DL-1:0]     dec_write_en;
  logic [DL*TW-1:0]  dec_write_tag;
  logic [WP*RW-1:0]  rob_WB_target;
  logic [WP*OW-1:0]  rob_WB_data;
  logic [WP*TW-1:0]  rob_WB_tag;
  logic [WP-1:0]     rob_WB_en;
  logic [SL*OW-1:0]  rob_read_data;
  logic [SL-1:0]     rob_read_valid_bit;
  logic [SL*TW-1:0]  rob_read_tag;
  logic [SL-1:0]     rob_read_ready;

  regfile_tagged_mp #(
    .OPRAND_WIDTH(OW), .ARRAY_ENTRY(AE), .REGNAME_WIDTH(RW),
    .ROB_TAG_WIDTH(TW), .DEC_LANES(DL), .WB_PORTS(WP)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_read_addr(dec_read_addr), .dec_read_en(dec_read_en),
    .dec_write_addr(dec_write_addr), .dec_write_en(dec_write_en), .dec_write_tag(dec_write_tag),
    .rob_WB_target(rob_WB_target), .rob_WB_data(rob_WB_data), .rob_WB_tag(rob_WB_tag), .rob_WB_en(rob_WB_en),
    .rob_read_data(rob_read_data), .rob_read_valid_bit(rob_read_valid_bit),
    .rob_read_tag(rob_read_tag), .rob_read_ready(rob_read_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          valid;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb [SL][$];
  int checks = 0;
  int errors = 0;

  task automatic clr();
    flush = 0; dec_read_addr = '0; dec_read_en = '0;
    dec_write_addr = '0; dec_write_en = '0; dec_write_tag = '0;
    rob_WB_target = '0; rob_WB_data = '0; rob_WB_tag = '0; rob_WB_en = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic rd(input int slot, input logic [RW-1:0] a,
                    input logic [OW-1:0] d, input logic v, input logic [TW-1:0] t);
    exp_t e;
    dec_read_addr[slot*RW +: RW] = a;
    dec_read_en[slot] = 1'b1;
    e.data = d; e.valid = v; e.tag = t;
    sb[slot].push_back(e);
  endtask

  task automatic claim(input int lane, input logic [RW-1:0] a, input logic [TW-1:0] t);
    dec_write_addr[lane*RW +: RW] = a;
    dec_write_tag[lane*TW +: TW] = t;
    dec_write_en[lane] = 1'b1;
  endtask

  task automatic wb(input int port, input logic [RW-1:0] a, input logic [OW-1:0] d, input logic [TW-1:0] t);
    rob_WB_target[port*RW +: RW] = a;
    rob_WB_data[port*OW +: OW] = d;
    rob_WB_tag[port*TW +: TW] = t;
    rob_WB_en[port] = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < SL; k++) begin
        if (rob_read_ready[k]) begin
          checks++;
          if (sb[k].size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready slot%0d: got ready 1 expected 0", k);
          end else begin
            exp_t e;
            exp_t a;
            e = sb[k].pop_front();
            a.data = rob_read_data[k*OW +: OW];
            a.valid = rob_read_valid_bit[k];
            a.tag = rob_read_tag[k*TW +: TW];
            if (a !== e) begin
              errors++;
              $display("FAIL read slot%0d t=%0t: got data %h valid %b tag %h expected data %h valid %b tag %h",
                       k, $time, a.data, a.valid, a.tag, e.data, e.valid, e.tag);
            end
          end
        end
      end
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    dec_read_en = '1;           // read during reset must not produce ready
    @(posedge clk);
    #1;
    clr();
    chk("reset_data", 64'(rob_read_data), 64'd0);
    chk("reset_valid", 64'(rob_read_valid_bit), 64'hF);
    chk("reset_tag", 64'(rob_read_tag), 64'd0);
    chk("reset_ready", 64'(rob_read_ready), 64'd0);
    rst = 1'b0;
    tick();

    // all slots read r3 after reset
    for (int k = 0; k < SL; k++) rd(k, 5'd3, 16'h0000, 1'b1, 4'h0);
    tick();

    // claim then matching writeback, with same-cycle forwarding
    claim(0, 5'd5, 4'd7);
    tick();
    wb(0, 5'd5, 16'h1234, 4'd7);
    rd(1, 5'd5, 16'h1234, 1'b1, 4'd7);
    tick();
    rd(0, 5'd5, 16'h1234, 1'b1, 4'd7);
    tick();

    // stale-tag writeback updates data only
    claim(0, 5'd5, 4'd2);
    tick();
    claim(0, 5'd5, 4'd9);
    tick();
    wb(0, 5'd5, 16'hBEEF, 4'd2);
    tick();
    rd(0, 5'd5, 16'hBEEF, 1'b0, 4'd9);
    tick();

    // older-lane overlay on top of forwarded writeback
    claim(0, 5'd4, 4'd3);
    wb(1, 5'd4, 16'h0055, 4'd0);
    rd(2, 5'd4, 16'h0055, 1'b0, 4'd3);
    rd(0, 5'd4, 16'h0055, 1'b1, 4'd0);
    tick();
    rd(3, 5'd4, 16'h0055, 1'b0, 4'd3);
    tick();

    // highest port / highest lane win
    wb(0, 5'd10, 16'h1111, 4'd0);
    wb(1, 5'd10, 16'h2222, 4'd0);
    claim(0, 5'd11, 4'd1);
    claim(1, 5'd11, 4'd2);
    tick();
    rd(0, 5'd10, 16'h2222, 1'b1, 4'd0);
    rd(1, 5'd11, 16'h0000, 1'b0, 4'd2);
    tick();

    // flush clears pending producers and discards same-cycle claims
    claim(0, 5'd6, 4'd1);
    claim(1, 5'd7, 4'd2);
    tick();
    flush = 1'b1;
    claim(0, 5'd8, 4'd4);
    dec_read_addr[0 +: RW] = 5'd6;
    dec_read_en[0] = 1'b1;      // no ready expected in the cycle after flush
    tick();
    rd(0, 5'd6, 16'h0000, 1'b1, 4'd1);
    rd(1, 5'd7, 16'h0000, 1'b1, 4'd2);
    rd(2, 5'd8, 16'h0000, 1'b1, 4'd0);
    rd(3, 5'd5, 16'hBEEF, 1'b1, 4'd9);
    tick();

    // entry 0 behaviour
    wb(0, 5'd0, 16'hFFFF, 4'd0);
    tick();
    claim(0, 5'd0, 4'd5);
`ifdef REGFILE_ZERO_REG_EN
    rd(2, 5'd0, 16'h0000, 1'b1, 4'd0);
`else
    rd(2, 5'd0, 16'hFFFF, 1'b0, 4'd5);
`endif
    tick();
`ifdef REGFILE_ZERO_REG_EN
    rd(0, 5'd0, 16'h0000, 1'b1, 4'd0);
`else
    rd(0, 5'd0, 16'hFFFF, 1'b0, 4'd5);
`endif
    tick();

    repeat (3) tick();
    for (int k = 0; k < SL; k++) chk($sformatf("pending_slot%0d", k), 64'(sb[k].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
